// File: rtl/bp_mem_clk_ctrl.sv
// Memory clock-enable controller: tracks outstanding CCE<->bp_mem transactions and gates the memory clock when idle.
// Optional macro BP_MEM_CLK_CTRL_STATS_EN adds a saturating SLEEP-cycle counter on sleep_cycles_o.
module bp_mem_clk_ctrl #(
  parameter int max_outstanding_p = 4,
  parameter int wake_cycles_p     = 2,
  parameter int idle_cycles_p     = 8,
  localparam int cnt_width_lp     = (max_outstanding_p + 1 <= 2) ? 1 : $clog2(max_outstanding_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    mem_cmd_v_i,
  output logic                    mem_cmd_v_o,
  input  logic                    mem_cmd_yumi_i,
  output logic                    mem_cmd_yumi_o,
  input  logic                    mem_data_cmd_v_i,
  output logic                    mem_data_cmd_v_o,
  input  logic                    mem_data_cmd_yumi_i,
  output logic                    mem_data_cmd_yumi_o,
  input  logic                    mem_resp_v_i,
  output logic                    mem_resp_v_o,
  input  logic                    mem_resp_ready_i,
  input  logic                    mem_data_resp_v_i,
  output logic                    mem_data_resp_v_o,
  input  logic                    mem_data_resp_ready_i,
  output logic                    mem_clk_en_o,
  output logic [cnt_width_lp-1:0] outstanding_o,
  output logic                    busy_o,
  output logic                    error_o,
  output logic [31:0]             sleep_cycles_o
);

  localparam int tmr_max_lp   = (wake_cycles_p > idle_cycles_p) ? wake_cycles_p : idle_cycles_p;
  localparam int tmr_width_lp = (tmr_max_lp + 1 <= 2) ? 1 : $clog2(tmr_max_lp + 1);

  typedef enum logic [1:0] {SLEEP, WAKE, ACTIVE, DRAIN} state_e;

  state_e                  state;
  logic [tmr_width_lp-1:0] tmr;
  logic                    awake, room, pass;
  logic                    cmd_any, resp_any;
  logic [1:0]              inc, dec;
  logic [cnt_width_lp:0]   nxt;

  // Reset parks the FSM in DRAIN, so gate everything on reset_i explicitly.
  assign awake = ((state == ACTIVE) || (state == DRAIN)) && !reset_i;
  assign room  = ({1'b0, outstanding_o} + (cnt_width_lp+1)'(2)) <= (cnt_width_lp+1)'(max_outstanding_p);
  assign pass  = awake && room;

  assign mem_cmd_v_o         = mem_cmd_v_i & pass;
  assign mem_cmd_yumi_o      = mem_cmd_yumi_i & pass;
  assign mem_data_cmd_v_o    = mem_data_cmd_v_i & pass;
  assign mem_data_cmd_yumi_o = mem_data_cmd_yumi_i & pass;
  assign mem_resp_v_o        = mem_resp_v_i & awake;
  assign mem_data_resp_v_o   = mem_data_resp_v_i & awake;

  assign cmd_any  = mem_cmd_v_i | mem_data_cmd_v_i;
  assign resp_any = mem_resp_v_i | mem_data_resp_v_i;

  assign inc = {1'b0, mem_cmd_v_o & mem_cmd_yumi_i} + {1'b0, mem_data_cmd_v_o & mem_data_cmd_yumi_i};
  assign dec = {1'b0, mem_resp_v_o & mem_resp_ready_i} + {1'b0, mem_data_resp_v_o & mem_data_resp_ready_i};
  // Two's-complement in one extra bit; the MSB flags an underflow.
  assign nxt = {1'b0, outstanding_o} + (cnt_width_lp+1)'(inc) - (cnt_width_lp+1)'(dec);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      outstanding_o <= '0;
      error_o       <= 1'b0;
    end else if (nxt[cnt_width_lp]) begin
      outstanding_o <= '0;
      error_o       <= 1'b1;
    end else begin
      outstanding_o <= nxt[cnt_width_lp-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state        <= DRAIN;
      tmr          <= tmr_width_lp'(idle_cycles_p);
      mem_clk_en_o <= 1'b1;
      busy_o       <= 1'b0;
    end else begin
      case (state)
        SLEEP: if (cmd_any) begin
          state        <= WAKE;
          tmr          <= tmr_width_lp'(wake_cycles_p);
          mem_clk_en_o <= 1'b1;
        end
        WAKE: if (tmr == tmr_width_lp'(1)) begin
          state  <= ACTIVE;
          busy_o <= 1'b1;
        end else begin
          tmr <= tmr - tmr_width_lp'(1);
        end
        ACTIVE: if ((outstanding_o == '0) && !cmd_any && !resp_any) begin
          state  <= DRAIN;
          tmr    <= tmr_width_lp'(idle_cycles_p);
          busy_o <= 1'b0;
        end
        DRAIN: if (cmd_any || resp_any) begin
          state  <= ACTIVE;
          busy_o <= 1'b1;
        end else if (tmr == tmr_width_lp'(1)) begin
          state        <= SLEEP;
          mem_clk_en_o <= 1'b0;
        end else begin
          tmr <= tmr - tmr_width_lp'(1);
        end
        default: state <= DRAIN;
      endcase
    end
  end

`ifdef BP_MEM_CLK_CTRL_STATS_EN
  logic [31:0] sleep_q;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      sleep_q <= '0;
    else if ((state == SLEEP) && (sleep_q != '1))
      sleep_q <= sleep_q + 32'd1;
  end
  assign sleep_cycles_o = sleep_q;
`else
  assign sleep_cycles_o = '0;
`endif

endmodule

// File: tb/tb_bp_mem_clk_ctrl.sv
// Scoreboard bench for bp_mem_clk_ctrl: stimulus pushes per-cycle expectations, a negedge monitor pops and compares.
module tb_bp_mem_clk_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_v, cmd_yumi, dcmd_v, dcmd_yumi;
  logic        resp_v, resp_rdy, dresp_v, dresp_rdy;
  logic        cmd_v_o, cmd_yumi_o, dcmd_v_o, dcmd_yumi_o, resp_v_o, dresp_v_o;
  logic        clk_en, busy, err;
  logic [2:0]  cnt;
  logic [31:0] sleep_cyc;

  bp_mem_clk_ctrl #(.max_outstanding_p(4), .wake_cycles_p(2), .idle_cycles_p(8)) dut (
    .clk_i(clk), .reset_i(rst),
    .mem_cmd_v_i(cmd_v), .mem_cmd_v_o(cmd_v_o),
    .mem_cmd_yumi_i(cmd_yumi), .mem_cmd_yumi_o(cmd_yumi_o),
    .mem_data_cmd_v_i(dcmd_v), .mem_data_cmd_v_o(dcmd_v_o),
    .mem_data_cmd_yumi_i(dcmd_yumi), .mem_data_cmd_yumi_o(dcmd_yumi_o),
    .mem_resp_v_i(resp_v), .mem_resp_v_o(resp_v_o), .mem_resp_ready_i(resp_rdy),
    .mem_data_resp_v_i(dresp_v), .mem_data_resp_v_o(dresp_v_o), .mem_data_resp_ready_i(dresp_rdy),
    .mem_clk_en_o(clk_en), .outstanding_o(cnt), .busy_o(busy), .error_o(err),
    .sleep_cycles_o(sleep_cyc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  int   zero_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sample(int s);
    case (s)
      0:  return {31'd0, clk_en};
      1:  return {31'd0, cmd_v_o};
      2:  return {31'd0, cmd_yumi_o};
      3:  return {31'd0, dcmd_v_o};
      4:  return {31'd0, dcmd_yumi_o};
      5:  return {31'd0, resp_v_o};
      6:  return {31'd0, dresp_v_o};
      7:  return {29'd0, cnt};
      8:  return {31'd0, busy};
      9:  return {31'd0, err};
      default: return sleep_cyc;
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] act;
      e = sb.pop_front();
      act = sample(e.sig);
      total++;
      if (e.cyc < cyc)
        $display("FAIL %s: expectation for cycle %0d never checked (now %0d)", e.name, e.cyc, cyc);
      else if (act !== e.val)
        $display("FAIL %s: cycle %0d got %0d expected %0d", e.name, cyc, act, e.val);
      else
        passed++;
    end
    if (clk_en === 1'b0) zero_en++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, int sig, logic [31:0] val);
    exp_t e;
    e.cyc = cyc; e.sig = sig; e.val = val; e.name = name;
    sb.push_back(e);
  endtask

  task automatic idle_inputs();
    cmd_v = 0; cmd_yumi = 0; dcmd_v = 0; dcmd_yumi = 0;
    resp_v = 0; resp_rdy = 0; dresp_v = 0; dresp_rdy = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (2) tick();
    // Reset: valids in, nothing qualified out.
    cmd_v = 1; cmd_yumi = 1; resp_v = 1; dresp_v = 1;
    chk("rst_en", 0, 1);      chk("rst_cmd_v", 1, 0);  chk("rst_cmd_yumi", 2, 0);
    chk("rst_resp_v", 5, 0);  chk("rst_dresp_v", 6, 0); chk("rst_cnt", 7, 0);
    chk("rst_busy", 8, 0);    chk("rst_err", 9, 0);    chk("rst_sleep", 10, 0);
    tick();
    idle_inputs();
    rst = 1'b0;
    chk("rel_en_first", 0, 1);
    repeat (7) tick();
    chk("rel_en_last", 0, 1);
    tick();
    chk("rel_en_off", 0, 0);  chk("rel_busy", 8, 0);
    repeat (3) tick();

    // Wake from SLEEP with yumi held high throughout.
    cmd_v = 1; cmd_yumi = 1;
    chk("wake_en_t", 0, 0);   chk("wake_cmd_v_t", 1, 0); chk("wake_yumi_t", 2, 0);
    tick();
    chk("wake_en_t1", 0, 1);  chk("wake_yumi_t1", 2, 0);
    tick();
    chk("wake_cmd_v_t2", 1, 0);
    tick();
    chk("wake_cmd_v_t3", 1, 1); chk("wake_yumi_t3", 2, 1); chk("wake_busy_t3", 8, 1);
    tick();
    cmd_v = 0; cmd_yumi = 0; dcmd_v = 1; dcmd_yumi = 1;
    chk("wake_cnt_t4", 7, 1); chk("dcmd_pass", 3, 1);
    tick();
    cmd_v = 1; cmd_yumi = 1;
    chk("cnt_2", 7, 2);       chk("dual_cmd_pass", 1, 1);

    // Back-pressure at a full count.
    tick();
    chk("bp_cnt4", 7, 4);     chk("bp_cmd_v", 1, 0);   chk("bp_cmd_yumi", 2, 0);
    chk("bp_dcmd_v", 3, 0);   chk("bp_dcmd_yumi", 4, 0);
    tick();
    resp_v = 1; resp_rdy = 1;
    chk("bp_resp_v", 5, 1);   chk("bp_cmd_v_resp", 1, 0);
    tick();
    chk("bp_cnt3", 7, 3);     chk("bp_one_slot", 1, 0);
    tick();
    resp_v = 0; resp_rdy = 0; dcmd_v = 0; dcmd_yumi = 0;
    dresp_v = 1; dresp_rdy = 1;
    chk("bp_cnt2", 7, 2);     chk("bp_cmd_v_again", 1, 1); chk("simul_dresp_v", 6, 1);
    tick();
    cmd_v = 0; cmd_yumi = 0; resp_v = 1; resp_rdy = 1;
    chk("simul_cnt", 7, 2);
    tick();
    idle_inputs();
    chk("both_resp_cnt", 7, 0); chk("idle_busy", 8, 1);
    tick();
    chk("drain_busy", 8, 0);  chk("drain_en", 0, 1);

    // Abort DRAIN at counter 3 with a data command.
    repeat (5) tick();
    dcmd_v = 1; dcmd_yumi = 1;
    chk("abort_dcmd_v", 3, 1); chk("abort_dcmd_yumi", 4, 1); chk("abort_busy_pre", 8, 0);
    tick();
    dcmd_v = 0; dcmd_yumi = 0; dresp_v = 1; dresp_rdy = 1;
    chk("abort_busy", 8, 1);  chk("abort_cnt", 7, 1);

    // Underflow at zero count.
    tick();
    dresp_v = 0; dresp_rdy = 0; resp_v = 1; resp_rdy = 1;
    chk("uf_cnt_pre", 7, 0);  chk("uf_resp_v", 5, 1); chk("uf_err_pre", 9, 0);
    tick();
    idle_inputs();
    chk("uf_cnt", 7, 0);      chk("uf_err", 9, 1);     chk("uf_busy", 8, 1);
    tick();
    chk("uf_drain_busy", 8, 0); chk("uf_err_sticky", 9, 1);
    repeat (7) tick();
    chk("idle_en_last", 0, 1);
    tick();
    chk("idle_en_off", 0, 0); chk("err_sticky_sleep", 9, 1);
`ifdef BP_MEM_CLK_CTRL_STATS_EN
    chk("sleep_stat", 10, zero_en);
`else
    chk("sleep_stat", 10, 0);
`endif
    tick();
    rst = 1'b1;
    chk("rst2_err", 9, 0);    chk("rst2_en", 0, 1);    chk("rst2_cnt", 7, 0);
    repeat (2) tick();

    if (sb.size() != 0) begin
      total++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
